// File: rtl/fadder_resp_checker.sv
// fadder_resp_checker
// Response analyser for the full-adder fault-injection campaign. Each accepted sample
// {a,b,cin,sum,cout} is compared against the golden a+b+cin. Per-campaign mismatch
// results are reported with a one-cycle done strobe, and a sticky coverage map records
// every fault index that has been detected.
// Optional idle-sample watchdog: define FCHK_TIMEOUT_EN.
module fadder_resp_checker #(
    parameter int unsigned NUM_FAULTS  = 9,
    parameter int unsigned FID_W       = 4,
    parameter int unsigned TIMEOUT_CYC = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [FID_W-1:0]      fault_id,
    input  logic                  vld,
    input  logic                  a,
    input  logic                  b,
    input  logic                  cin,
    input  logic                  sum,
    input  logic                  cout,
    output logic                  busy,
    output logic                  done,
    output logic [FID_W-1:0]      res_fault_id,
    output logic [3:0]            err_cnt,
    output logic [7:0]            err_mask,
    output logic                  detected,
    output logic [NUM_FAULTS-1:0] cov_mask,
    output logic                  proto_err,
    output logic                  timeout
);

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StCollect = 2'd1,
        StReport  = 2'd2
    } state_e;

    state_e                state_q, state_d;
    logic [FID_W-1:0]      fid_q, fid_d;
    logic [3:0]            err_cnt_q, err_cnt_d;
    logic [7:0]            err_mask_q, err_mask_d;
    logic [7:0]            seen_q, seen_d;
    logic [3:0]            smp_cnt_q, smp_cnt_d;
    logic [NUM_FAULTS-1:0] cov_q, cov_d;
    logic                  proto_q, proto_d;

    logic [2:0] vec_idx;
    logic [1:0] golden;
    logic       mismatch;
    logic       accept;
    logic       last_sample;
    logic       campaign_start;
    logic       proto_viol;
    logic       timeout_hit;

    // Sample decode, golden compare and protocol-violation detection.
    always_comb begin
        vec_idx        = {cin, b, a};
        golden         = {1'b0, a} + {1'b0, b} + {1'b0, cin};
        mismatch       = (golden != {cout, sum});
        accept         = (state_q == StCollect) && vld;
        last_sample    = accept && (smp_cnt_q == 4'd7);
        // A new campaign may be launched from IDLE or straight out of the REPORT cycle.
        campaign_start = start && ((state_q == StIdle) || (state_q == StReport));
        proto_viol     = (vld && (state_q != StCollect))
                       || (start && (state_q == StCollect))
                       || (accept && seen_q[vec_idx]);
    end

`ifdef FCHK_TIMEOUT_EN
    localparam int unsigned     TmoW    = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TmoW-1:0] TmoLast = TmoW'(TIMEOUT_CYC - 1);

    logic [TmoW-1:0] tmo_cnt_q, tmo_cnt_d;
    logic            timeout_q, timeout_d;

    // Idle watchdog: counts COLLECT cycles since the last accepted sample.
    always_comb begin
        tmo_cnt_d   = tmo_cnt_q;
        timeout_d   = timeout_q;
        timeout_hit = (state_q == StCollect) && !vld && (tmo_cnt_q == TmoLast);
        if (campaign_start) begin
            tmo_cnt_d = '0;
            timeout_d = 1'b0;
        end else if (accept) begin
            tmo_cnt_d = '0;
        end else if (state_q == StCollect) begin
            tmo_cnt_d = tmo_cnt_q + TmoW'(1);
        end
        if (timeout_hit) begin
            timeout_d = 1'b1;
        end
    end

    // Watchdog registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tmo_cnt_q <= '0;
            timeout_q <= 1'b0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign timeout = timeout_q;
`else
    assign timeout_hit = 1'b0;
    assign timeout     = 1'b0;
`endif

    // A zero limit would leave the watchdog no idle cycle to count.
    a_tmo_cfg : assert property (@(posedge clk) TIMEOUT_CYC >= 1);

    // Campaign FSM: next state and status outputs.
    always_comb begin
        state_d = state_q;
        busy    = 1'b0;
        done    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StCollect;
                end
            end
            StCollect: begin
                busy = 1'b1;
                if (last_sample || timeout_hit) begin
                    state_d = StReport;
                end
            end
            StReport: begin
                done    = 1'b1;
                state_d = start ? StCollect : StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Campaign state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Result accumulation, sticky coverage and sticky protocol error.
    always_comb begin
        fid_d      = fid_q;
        err_cnt_d  = err_cnt_q;
        err_mask_d = err_mask_q;
        seen_d     = seen_q;
        smp_cnt_d  = smp_cnt_q;
        cov_d      = cov_q;
        proto_d    = proto_q;

        // Coverage uses the finishing campaign's results before any relaunch clears them.
        if ((state_q == StReport) && (err_cnt_q != 4'd0)) begin
            for (int unsigned f = 0; f < NUM_FAULTS; f++) begin
                if (32'(fid_q) == f) begin
                    cov_d[f] = 1'b1;
                end
            end
        end

        if (campaign_start) begin
            fid_d      = fault_id;
            err_cnt_d  = 4'd0;
            err_mask_d = 8'h00;
            seen_d     = 8'h00;
            smp_cnt_d  = 4'd0;
        end

        // A repeated vector still counts toward the eight and is still checked.
        if (accept) begin
            smp_cnt_d       = smp_cnt_q + 4'd1;
            seen_d[vec_idx] = 1'b1;
            if (mismatch) begin
                err_cnt_d           = err_cnt_q + 4'd1;
                err_mask_d[vec_idx] = 1'b1;
            end
        end

        if (proto_viol) begin
            proto_d = 1'b1;
        end
    end

    // Result and sticky-status registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fid_q      <= '0;
            err_cnt_q  <= 4'd0;
            err_mask_q <= 8'h00;
            seen_q     <= 8'h00;
            smp_cnt_q  <= 4'd0;
            cov_q      <= '0;
            proto_q    <= 1'b0;
        end else begin
            fid_q      <= fid_d;
            err_cnt_q  <= err_cnt_d;
            err_mask_q <= err_mask_d;
            seen_q     <= seen_d;
            smp_cnt_q  <= smp_cnt_d;
            cov_q      <= cov_d;
            proto_q    <= proto_d;
        end
    end

    assign res_fault_id = fid_q;
    assign err_cnt      = err_cnt_q;
    assign err_mask     = err_mask_q;
    assign detected     = (err_cnt_q != 4'd0);
    assign cov_mask     = cov_q;
    assign proto_err    = proto_q;

endmodule

// File: tb/tb_fadder_resp_checker.sv
// Bench for fadder_resp_checker: table-driven fault campaigns, randomized campaigns
// against a reference model, and hand-written protocol / reset / relaunch / watchdog cases.
module tb_fadder_resp_checker;

    logic       clk, rst_n, start, vld, a, b, cin, sum, cout;
    logic [3:0] fault_id, res_fault_id, err_cnt;
    logic [7:0] err_mask;
    logic       busy, done, detected, proto_err, timeout;
    logic [8:0] cov_mask;

    int         checks = 0;
    int         errors = 0;
    logic [8:0] cov_model;

    typedef struct {
        logic [3:0] fid;
        int         kind;
        int         ecnt;
        logic [7:0] emask;
    } camp_t;

    camp_t tbl[6];

    fadder_resp_checker dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .fault_id    (fault_id),
        .vld         (vld),
        .a           (a),
        .b           (b),
        .cin         (cin),
        .sum         (sum),
        .cout        (cout),
        .busy        (busy),
        .done        (done),
        .res_fault_id(res_fault_id),
        .err_cnt     (err_cnt),
        .err_mask    (err_mask),
        .detected    (detected),
        .cov_mask    (cov_mask),
        .proto_err   (proto_err),
        .timeout     (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Fault injector: 0 none, 1 sum sa0, 2 sum sa1, 3 cout sa0, 4 cout sa1, 5 sum inverted.
    function automatic logic [1:0] faulty_obs(input int kind, input logic [2:0] v);
        int         s;
        logic [1:0] o;
        s = int'(v[0]) + int'(v[1]) + int'(v[2]);
        o = 2'(s);
        case (kind)
            1: o[0] = 1'b0;
            2: o[0] = 1'b1;
            3: o[1] = 1'b0;
            4: o[1] = 1'b1;
            5: o[0] = ~o[0];
            default: ;
        endcase
        return o;
    endfunction

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        cov_model = '0;
    endtask

    task automatic do_start(input logic [3:0] fid);
        start    = 1'b1;
        fault_id = fid;
        tick();
        start    = 1'b0;
    endtask

    task automatic send(input logic [2:0] v, input logic [1:0] obs);
        vld  = 1'b1;
        a    = v[0];
        b    = v[1];
        cin  = v[2];
        sum  = obs[0];
        cout = obs[1];
        tick();
        vld  = 1'b0;
    endtask

    // Called on the cycle done is expected.
    task automatic report_check(input string name, input logic [3:0] fid, input int ecnt,
                                input logic [7:0] emask);
        chk({name, ".done"}, done, 1'b1);
        chk({name, ".busy"}, busy, 1'b0);
        chk({name, ".res_fid"}, res_fault_id, fid);
        chk({name, ".err_cnt"}, err_cnt, ecnt);
        chk({name, ".err_mask"}, err_mask, emask);
        chk({name, ".detected"}, detected, ecnt != 0);
        chk({name, ".timeout"}, timeout, 1'b0);
        if (ecnt != 0 && fid < 9) cov_model[fid] = 1'b1;
    endtask

    task automatic idle_check(input string name);
        chk({name, ".idle_done"}, done, 1'b0);
        chk({name, ".idle_busy"}, busy, 1'b0);
        chk({name, ".cov_mask"}, cov_mask, cov_model);
    endtask

    initial begin
        int         perm[8];
        int         ecnt, pulses, waited, j, t;
        logic [7:0] emask;
        logic [3:0] fid;
        logic [1:0] obs;
        logic [2:0] v;

        tbl[0] = '{fid: 4'd0,  kind: 0, ecnt: 0, emask: 8'h00};
        tbl[1] = '{fid: 4'd3,  kind: 1, ecnt: 4, emask: 8'h96};
        tbl[2] = '{fid: 4'd5,  kind: 2, ecnt: 4, emask: 8'h69};
        tbl[3] = '{fid: 4'd2,  kind: 3, ecnt: 4, emask: 8'hE8};
        tbl[4] = '{fid: 4'd12, kind: 4, ecnt: 4, emask: 8'h17};
        tbl[5] = '{fid: 4'd7,  kind: 5, ecnt: 8, emask: 8'hFF};

        rst_n = 1'b0; start = 1'b0; vld = 1'b0; fault_id = 4'd0;
        a = 1'b0; b = 1'b0; cin = 1'b0; sum = 1'b0; cout = 1'b0;
        cov_model = '0;
        tick();
        tick();
        rst_n = 1'b1;
        chk("rst.busy", busy, 1'b0);
        chk("rst.done", done, 1'b0);
        chk("rst.err_cnt", err_cnt, 4'd0);
        chk("rst.err_mask", err_mask, 8'h00);
        chk("rst.cov_mask", cov_mask, 9'h000);
        chk("rst.proto_err", proto_err, 1'b0);
        chk("rst.timeout", timeout, 1'b0);

        // Table-driven campaigns, vectors in order 0..7.
        for (int i = 0; i < 6; i++) begin
            do_start(tbl[i].fid);
            chk("tbl.busy", busy, 1'b1);
            for (int k = 0; k < 8; k++) send(3'(k), faulty_obs(tbl[i].kind, 3'(k)));
            report_check("tbl", tbl[i].fid, tbl[i].ecnt, tbl[i].emask);
            tick();
            idle_check("tbl");
        end

        // Randomized campaigns: shuffled vector order, random corruption, random gaps.
        for (int n = 0; n < 24; n++) begin
            fid = 4'($urandom_range(0, 15));
            for (int k = 0; k < 8; k++) perm[k] = k;
            for (int k = 7; k > 0; k--) begin
                j = $urandom_range(0, k);
                t = perm[k]; perm[k] = perm[j]; perm[j] = t;
            end
            ecnt  = 0;
            emask = 8'h00;
            do_start(fid);
            for (int k = 0; k < 8; k++) begin
                v   = 3'(perm[k]);
                obs = 2'(int'(v[0]) + int'(v[1]) + int'(v[2]));
                if ($urandom_range(0, 3) == 0) obs = obs ^ 2'($urandom_range(1, 3));
                if (int'(obs) != int'(v[0]) + int'(v[1]) + int'(v[2])) begin
                    ecnt++;
                    emask[perm[k]] = 1'b1;
                end
                repeat ($urandom_range(0, 2)) tick();
                send(v, obs);
            end
            report_check("rnd", fid, ecnt, emask);
            tick();
            idle_check("rnd");
        end

        // vld outside COLLECT sets the sticky protocol error.
        chk("proto.pre", proto_err, 1'b0);
        vld = 1'b1;
        tick();
        vld = 1'b0;
        chk("proto.idle_vld", proto_err, 1'b1);
        chk("proto.idle_busy", busy, 1'b0);
        do_start(4'd0);
        for (int k = 0; k < 8; k++) send(3'(k), faulty_obs(0, 3'(k)));
        report_check("proto.after", 4'd0, 0, 8'h00);
        chk("proto.sticky", proto_err, 1'b1);
        tick();

        // Repeated vector 5: flagged, still counted, done after 8 samples.
        do_reset();
        chk("rep.cleared", proto_err, 1'b0);
        do_start(4'd8);
        for (int k = 0; k < 8; k++) begin
            v = (k == 6) ? 3'd5 : 3'(k);
            send(v, faulty_obs(0, v));
            if (k == 5) chk("rep.before", proto_err, 1'b0);
            if (k == 6) chk("rep.flag", proto_err, 1'b1);
        end
        report_check("rep", 4'd8, 0, 8'h00);
        tick();
        idle_check("rep");

        // start during COLLECT is ignored and flagged.
        do_reset();
        do_start(4'd6);
        for (int k = 0; k < 3; k++) send(3'(k), faulty_obs(2, 3'(k)));
        do_start(4'd9);
        chk("scol.proto", proto_err, 1'b1);
        chk("scol.busy", busy, 1'b1);
        for (int k = 3; k < 8; k++) send(3'(k), faulty_obs(2, 3'(k)));
        report_check("scol", 4'd6, 4, 8'h69);
        tick();
        idle_check("scol");

        // vld and start together in IDLE: start wins, the sample is dropped.
        do_reset();
        start = 1'b1; fault_id = 4'd1; vld = 1'b1;
        a = 1'b1; b = 1'b0; cin = 1'b0; sum = 1'b0; cout = 1'b0;
        tick();
        start = 1'b0; vld = 1'b0;
        chk("sv.busy", busy, 1'b1);
        chk("sv.proto", proto_err, 1'b1);
        for (int k = 0; k < 8; k++) send(3'(k), faulty_obs(0, 3'(k)));
        report_check("sv", 4'd1, 0, 8'h00);
        tick();

        // Relaunch from the REPORT cycle.
        do_reset();
        do_start(4'd3);
        for (int k = 0; k < 8; k++) send(3'(k), faulty_obs(1, 3'(k)));
        report_check("b2b", 4'd3, 4, 8'h96);
        do_start(4'd4);
        chk("b2b.busy", busy, 1'b1);
        chk("b2b.done", done, 1'b0);
        chk("b2b.err_cnt", err_cnt, 4'd0);
        chk("b2b.err_mask", err_mask, 8'h00);
        chk("b2b.res_fid", res_fault_id, 4'd4);
        chk("b2b.cov", cov_mask, cov_model);
        for (int k = 0; k < 8; k++) send(3'(k), faulty_obs(0, 3'(k)));
        report_check("b2b2", 4'd4, 0, 8'h00);
        tick();
        idle_check("b2b2");
        chk("b2b.cov_val", cov_mask, 9'b000001000);

        // Reset after 5 samples aborts the campaign.
        do_start(4'd2);
        for (int k = 0; k < 5; k++) send(3'(k), faulty_obs(1, 3'(k)));
        chk("rstmid.cnt_pre", err_cnt, 4'd3);
        do_reset();
        chk("rstmid.busy", busy, 1'b0);
        chk("rstmid.done", done, 1'b0);
        chk("rstmid.err_cnt", err_cnt, 4'd0);
        chk("rstmid.err_mask", err_mask, 8'h00);
        chk("rstmid.cov", cov_mask, 9'h000);
        chk("rstmid.proto", proto_err, 1'b0);
        chk("rstmid.res_fid", res_fault_id, 4'd0);
        pulses = 0;
        for (int k = 0; k < 12; k++) begin
            tick();
            if (done) pulses++;
        end
        chk("rstmid.no_done", pulses, 0);

        // Three samples then silence.
        do_start(4'd1);
        send(3'd0, faulty_obs(0, 3'd0));
        send(3'd1, faulty_obs(1, 3'd1));
        send(3'd2, faulty_obs(0, 3'd2));
`ifdef FCHK_TIMEOUT_EN
        waited = 0;
        while (!done && waited < 200) begin
            tick();
            waited++;
        end
        chk("tmo.wait", waited, 64);
        chk("tmo.flag", timeout, 1'b1);
        chk("tmo.err_cnt", err_cnt, 4'd1);
        chk("tmo.err_mask", err_mask, 8'h02);
        chk("tmo.res_fid", res_fault_id, 4'd1);
        cov_model[1] = 1'b1;
        tick();
        chk("tmo.hold", timeout, 1'b1);
        chk("tmo.cov", cov_mask, cov_model);
        do_start(4'd0);
        chk("tmo.clear", timeout, 1'b0);
`else
        pulses = 0;
        waited = 0;
        for (int k = 0; k < 100; k++) begin
            tick();
            if (done) pulses++;
        end
        chk("notmo.busy", busy, 1'b1);
        chk("notmo.no_done", pulses, 0);
        chk("notmo.timeout", timeout, 1'b0);
        chk("notmo.err_cnt", err_cnt, 4'd1);
        chk("notmo.wait", waited, 0);
`endif
        do_reset();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
